sipo_frame_ctrl: RTL
====================

# sipo_frame_ctrl

Parametrised sequencer for serial-in/parallel-out sample capture from a multi-channel serial ADC front end. Each frame it issues a conversion strobe, then for every channel in turn waits a lead-in gap, enables the shift register for exactly one word and pulses word-done. A completed frame is presented on a valid/ready handshake so downstream buffering can apply backpressure. It sits between the sample trigger source and the per-channel SIPO shift registers and frame buffer.

## Interface
- WORD_BITS, 12: bits per channel word; legal range ≥2.
- NUM_CH, 4: channels per frame; legal range ≥1.
- CONV_CYCLES, 1: length of the conversion strobe in cycles; legal range ≥1.
- LEAD_CYCLES, 1: idle gap before each word's shift window; legal range ≥0.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- trig  in  1  frame start request, sampled each cycle.
- frame_ready  in  1  downstream accepts the completed frame.
- overrun_clr  in  1  clears the sticky overrun flag.
- convst  out  1  ADC conversion strobe.
- shift_en  out  1  SIPO shift enable, high for one bit per cycle.
- bit_idx  out  $clog2(WORD_BITS)  index of the bit being shifted, 0 first.
- ch_idx  out  max(1,$clog2(NUM_CH))  channel currently being captured.
- word_done  out  1  one-cycle pulse: word for ch_idx is complete.
- frame_valid  out  1  all NUM_CH words are captured; held until accepted.
- overrun  out  1  sticky: trig arrived while not IDLE.

## Operation
- States: IDLE, CONV, LEAD, SHIFT, LATCH, FRAME. All outputs are Moore-decoded from registered state and counters.
- IDLE: all strobes low; ch_idx=0. trig=1 → CONV.
- CONV: convst=1 for CONV_CYCLES cycles. Then → LEAD, or → SHIFT directly when LEAD_CYCLES=0.
- LEAD: all strobes low for LEAD_CYCLES cycles, then → SHIFT.
- SHIFT: shift_en=1 for WORD_BITS cycles. bit_idx counts 0..WORD_BITS-1 and returns to 0 on exit. Then → LATCH.
- LATCH: word_done=1 for one cycle.
  - If ch_idx=NUM_CH-1 → FRAME.
  - Otherwise ch_idx increments and the next state is LEAD, or SHIFT when LEAD_CYCLES=0.
- FRAME: frame_valid=1. On a cycle with frame_ready=1 → IDLE and ch_idx→0. frame_valid stays high until that cycle and is low on the next.
- trig is ignored outside IDLE. trig in the cycle after acceptance (already IDLE) starts a new frame.
- frame_ready outside FRAME has no effect.
- Reset (any time, including mid-frame): state IDLE, counters 0, every output 0, overrun 0. Capture resumes only on a fresh trig.

## Timing
- Reference point: trig sampled high at edge 0.
- convst is high in cycles 1..C (C=CONV_CYCLES).
- Channel k (0-based), with L=LEAD_CYCLES and W=WORD_BITS:
  - shift_en is high in cycles C+k(L+W+1)+L+1 .. C+k(L+W+1)+L+W.
  - word_done is high in cycle C+(k+1)(L+W+1).
- frame_valid first high in cycle C+NUM_CH(L+W+1)+1.
- With defaults: shift ch0 in cycles 3..14, word_done 15; ch1 shift 17..28; frame_valid from cycle 58.
- Minimum trig-to-trig period with frame_ready tied high: C+NUM_CH(L+W+1)+2 cycles.

## Configuration
- SIPO_FRAME_CTRL_OVERRUN_EN defined:
  - trig=1 in any state other than IDLE sets overrun on the next edge.
  - overrun_clr=1 clears it. If set and clear coincide, set wins.
- SIPO_FRAME_CTRL_OVERRUN_EN undefined: overrun is tied to 0, overrun_clr is ignored, and no flag register exists.

## Structure
- Shared package sipo_pkg holds the state enum (sipo_state_t) and width helper constants for bit_idx and ch_idx.
- One sub-module, sipo_phase_cnt: loadable down-counter with a terminal-count flag. It is reused for the CONV, LEAD and SHIFT durations. bit_idx is derived as W-1 minus the count.

## Test plan
- Defaults, single trig at cycle 0, frame_ready=1 → convst high cycle 1; shift_en windows 3..14, 17..28, 31..42, 45..56; word_done at 15, 29, 43, 57 with ch_idx 0..3; frame_valid high only at cycle 58.
- Defaults, frame_ready held 0 for 10 cycles after frame_valid rises → frame_valid stays high cycles 58..68; drop on cycle after ready=1; second trig then accepted.
- LEAD_CYCLES=0, NUM_CH=1, WORD_BITS=2 → convst cycle 1; shift_en cycles 2..3 with bit_idx 0,1; word_done cycle 4; frame_valid cycle 5.
- OVERRUN_EN defined, trig pulsed at cycle 20 mid-frame → frame timing unchanged; overrun=1 from cycle 21; overrun_clr and trig together → overrun stays 1; overrun_clr alone → 0.
- Reset asserted at cycle 30 (mid ch1 shift) → all outputs 0 immediately; after release, no activity until trig; next frame timing matches the first scenario.
- OVERRUN_EN undefined, trig mid-frame → overrun remains 0 throughout.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_pkg
//  Purpose  : Shared state enum and width helpers for the SIPO frame
//             sequencer and its phase counter.
//  Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_LEAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LATCH = 3'd4,
        ST_FRAME = 3'd5
    } sipo_state_t;

    // Index width for a range of n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width needed to hold values 0..maxval, never narrower than one bit
    function automatic int cnt_width(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

    // Widths of bit_idx / ch_idx for the default configuration
    localparam int DEF_BIT_IDX_W = idx_width(12);
    localparam int DEF_CH_IDX_W  = idx_width(4);

endpackage
`default_nettype wire

// File: rtl/sipo_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_phase_cnt
//  Purpose  : Loadable down-counter with terminal-count flag. Times the
//             conversion, lead-in and shift phases of the frame sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load a phase length (N-1), then count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_frame_ctrl
//  Purpose  : Frame sequencer for multi-channel serial ADC capture: issues
//             the conversion strobe, walks each channel through lead-in gap,
//             shift window and word-done, then offers the frame on a
//             valid/ready handshake.
//  Options  : SIPO_FRAME_CTRL_OVERRUN_EN - enables the sticky overrun flag
//             (trig seen while busy). Undefined: overrun tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WORD_BITS   = 12,
    parameter int NUM_CH      = 4,
    parameter int CONV_CYCLES = 1,
    parameter int LEAD_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           trig,
    input  logic                           frame_ready,
    input  logic                           overrun_clr,
    output logic                           convst,
    output logic                           shift_en,
    output logic [idx_width(WORD_BITS)-1:0] bit_idx,
    output logic [idx_width(NUM_CH)-1:0]    ch_idx,
    output logic                           word_done,
    output logic                           frame_valid,
    output logic                           overrun
);

    localparam int BIT_W = idx_width(WORD_BITS);
    localparam int CH_W  = idx_width(NUM_CH);

    // One counter serves all timed phases, so size it for the longest
    localparam int CNT_MAX_A = (CONV_CYCLES > WORD_BITS) ? CONV_CYCLES : WORD_BITS;
    localparam int CNT_MAX   = (LEAD_CYCLES > CNT_MAX_A) ? LEAD_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = cnt_width(CNT_MAX - 1);

    localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(WORD_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

    // With no lead-in gap the word's shift window follows directly
    localparam sipo_state_t      PRE_STATE = (LEAD_CYCLES > 0) ? ST_LEAD : ST_SHIFT;
    localparam logic [CNT_W-1:0] PRE_LOAD  = (LEAD_CYCLES > 0) ? LEAD_LOAD : SHIFT_LOAD;

    sipo_state_t      state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             convst_q, shift_en_q, word_done_q, frame_valid_q;
    logic             cnt_load_d;
    logic [CNT_W-1:0] cnt_load_val_d;
    logic [CNT_W-1:0] cnt_w;
    logic             cnt_tc_w;

    sipo_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_d),
        .load_val_i (cnt_load_val_d),
        .cnt_o      (cnt_w),
        .tc_o       (cnt_tc_w)
    );

    // Next state, channel advance and phase-counter reloads
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_load_d     = 1'b0;
        cnt_load_val_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d        = ST_CONV;
                    cnt_load_d     = 1'b1;
                    cnt_load_val_d = CONV_LOAD;
                end
            end
            ST_CONV: begin
                if (cnt_tc_w) begin
                    state_d        = PRE_STATE;
                    cnt_load_d     = 1'b1;
                    cnt_load_val_d = PRE_LOAD;
                end
            end
            ST_LEAD: begin
                if (cnt_tc_w) begin
                    state_d        = ST_SHIFT;
                    cnt_load_d     = 1'b1;
                    cnt_load_val_d = SHIFT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc_w) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (ch_q == LAST_CH) begin
                    state_d = ST_FRAME;
                end else begin
                    ch_d           = ch_q + CH_W'(1);
                    state_d        = PRE_STATE;
                    cnt_load_d     = 1'b1;
                    cnt_load_val_d = PRE_LOAD;
                end
            end
            ST_FRAME: begin
                if (frame_ready) begin
                    state_d = ST_IDLE;
                    ch_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // State register with strobes registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            convst_q      <= 1'b0;
            shift_en_q    <= 1'b0;
            word_done_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            convst_q      <= (state_d == ST_CONV);
            shift_en_q    <= (state_d == ST_SHIFT);
            word_done_q   <= (state_d == ST_LATCH);
            frame_valid_q <= (state_d == ST_FRAME);
        end
    end

    // Counter holds W-1 on the first shift cycle, so bit 0 goes out first
    generate
        if (CNT_W > BIT_W) begin : g_cnt_hi
            logic [CNT_W-BIT_W-1:0] unused_cnt_hi;
            assign unused_cnt_hi = cnt_w[CNT_W-1:BIT_W];
        end
    endgenerate

    assign bit_idx     = shift_en_q ? (BIT_LAST - cnt_w[BIT_W-1:0]) : '0;
    assign convst      = convst_q;
    assign shift_en    = shift_en_q;
    assign word_done   = word_done_q;
    assign frame_valid = frame_valid_q;
    assign ch_idx      = ch_q;

`ifdef SIPO_FRAME_CTRL_OVERRUN_EN
    logic overrun_q;

    // Sticky overrun: a new trigger while busy; setting beats clearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (trig && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = overrun_clr;
    assign overrun            = 1'b0;
`endif

endmodule
`default_nettype wire
